// File: rtl/cart_bank_ctl_if.sv
// Cartridge-port bus bundle: edge-connector selects/address/jumpers in, flash address/control and window enables out.
// Purely combinational wiring; no handshake, so neither side can stall the other.
interface cart_bank_ctl_if #(
    parameter int ROM_AW = 19
);
    logic [12:0]       cart_a;
    logic              s4_n;
    logic              s5_n;
    logic              cctl_n;
    logic              r_w;
    logic [1:0]        cfg;
    logic              rd4;
    logic              rd5;
    logic [ROM_AW-1:0] rom_a;
    logic              oe_n;
    logic              ce_n;
    logic              we_n;

    modport master (
        output cart_a, s4_n, s5_n, cctl_n, r_w, cfg,
        input  rd4, rd5, rom_a, oe_n, ce_n, we_n
    );

    modport slave (
        input  cart_a, s4_n, s5_n, cctl_n, r_w, cfg,
        output rd4, rd5, rom_a, oe_n, ce_n, we_n
    );
endinterface

// File: rtl/cart_bank_ctl.sv
// Atari XL/XE cartridge banking controller (plain 8k, OSS, SDX, XEGS) mapping CCTL writes onto flash address lines.
// Bank/enable registers update on rising phi2; flash address and data paths are combinational, no stalls.
module cart_bank_ctl #(
    parameter int          ROM_AW    = 19,
    parameter int          SDX_BITS  = 4,
    parameter int          XEGS_BITS = 3,
    parameter int unsigned SDX_BASE  = 'h00000,
    parameter int unsigned OSS_BASE  = 'h20000,
    parameter int unsigned CAR_BASE  = 'h28000,
    parameter int unsigned XEGS_BASE = 'h30000
) (
    input  logic            phi2,
    input  logic            reset_n,
    cart_bank_ctl_if.slave  bus,
    inout  wire  [7:0]      cart_d,
    inout  wire  [7:0]      rom_d
);
    typedef enum logic [1:0] {
        MODE_CAR  = 2'b00,
        MODE_OSS  = 2'b01,
        MODE_SDX  = 2'b10,
        MODE_XEGS = 2'b11
    } mode_e;

    localparam logic [7:0]        SDX_MASK  = 8'((1 << SDX_BITS) - 1);
    localparam logic [7:0]        XEGS_MASK = 8'((1 << XEGS_BITS) - 1);
    localparam logic [ROM_AW-1:0] SDX_B     = ROM_AW'(SDX_BASE);
    localparam logic [ROM_AW-1:0] OSS_B     = ROM_AW'(OSS_BASE);
    localparam logic [ROM_AW-1:0] CAR_B     = ROM_AW'(CAR_BASE);
    localparam logic [ROM_AW-1:0] XEGS_B    = ROM_AW'(XEGS_BASE);

    logic        init_q, init_d;
    mode_e       mode_q, mode_d;
    logic        rd4_q, rd4_d;
    logic        rd5_q, rd5_d;
    logic [7:0]  bank_q, bank_d;

    logic [12:0] a;
    logic        cctl_wr;
    logic        s4_en, s5_en, stat_sel, oss_bad, d_oe;
    logic [7:0]  d_dat;
    logic [ROM_AW-1:0] rom_a_c;
    logic        unused_bits;

    assign a       = bus.cart_a;
    assign cctl_wr = ~bus.cctl_n & ~bus.r_w;

    always_comb begin
        init_d = init_q;
        mode_d = mode_q;
        rd4_d  = rd4_q;
        rd5_d  = rd5_q;
        bank_d = bank_q;
        // The init cycle always wins over a coincident CCTL write.
        if (!init_q) begin
            init_d = 1'b1;
            mode_d = mode_e'(bus.cfg);
            rd4_d  = (bus.cfg == MODE_XEGS);
            rd5_d  = 1'b1;
            bank_d = (bus.cfg == MODE_SDX) ? SDX_MASK : 8'h00;
        end else if (cctl_wr) begin
            case (mode_q)
                MODE_SDX: begin
                    if (a[7:5] == 3'b111) begin
                        case (a[3:2])
                            2'b10: begin
                                rd5_d  = 1'b1;
                                mode_d = MODE_CAR;
                            end
                            2'b11: rd5_d = 1'b0;
                            default: begin
                                bank_d = 8'({~a[4], ~a[2:0]}) & SDX_MASK;
                                rd5_d  = 1'b1;
                            end
                        endcase
                    end
                end
                MODE_OSS: begin
                    if (a[3]) begin
                        rd5_d = 1'b0;
                    end else begin
                        rd5_d = 1'b1;
                        casez (a[3:0])
                            4'b0000: bank_d = 8'd0;
                            4'b0?11: bank_d = 8'd2;
                            4'b0100: bank_d = 8'd1;
                            default: bank_d = 8'd3;
                        endcase
                    end
                end
                MODE_XEGS: begin
                    bank_d = cart_d & XEGS_MASK;
                    rd4_d  = ~cart_d[7];
                    rd5_d  = ~cart_d[7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge phi2 or negedge reset_n) begin
        if (!reset_n) begin
            init_q <= 1'b0;
            mode_q <= MODE_CAR;
            rd4_q  <= 1'b0;
            rd5_q  <= 1'b0;
            bank_q <= 8'h00;
        end else begin
            init_q <= init_d;
            mode_q <= mode_d;
            rd4_q  <= rd4_d;
            rd5_q  <= rd5_d;
            bank_q <= bank_d;
        end
    end

    // $8000 select is checked first so a double select maps only one window.
    always_comb begin
        rom_a_c = '0;
        if (init_q) begin
            case (mode_q)
                MODE_XEGS: begin
                    if (!bus.s4_n)
                        rom_a_c = XEGS_B + ROM_AW'({bank_q[XEGS_BITS-1:0], a});
                    else if (!bus.s5_n)
                        rom_a_c = XEGS_B + ROM_AW'({{XEGS_BITS{1'b1}}, a});
                end
                MODE_SDX: if (!bus.s5_n)
                    rom_a_c = SDX_B + ROM_AW'({bank_q[SDX_BITS-1:0], a});
                MODE_OSS: if (!bus.s5_n)
                    rom_a_c = OSS_B + ROM_AW'({(a[12] ? 2'b11 : bank_q[1:0]), a[11:0]});
                default: if (!bus.s5_n)
                    rom_a_c = CAR_B + ROM_AW'(a);
            endcase
        end
    end

    assign s4_en    = rd4_q & ~bus.s4_n;
    assign s5_en    = rd5_q & ~bus.s5_n;
    assign stat_sel = ~bus.cctl_n & (a[7:0] == 8'hC0);
    assign oss_bad  = (mode_q == MODE_OSS) & (bank_q[1:0] == 2'b11) & ~a[12];
    assign d_oe     = phi2 & bus.r_w & (s4_en | s5_en | stat_sel);

    always_comb begin
        if (s4_en)
            d_dat = rom_d;
        else if (s5_en)
            d_dat = oss_bad ? 8'hFF : rom_d;
        else
            d_dat = {mode_q, rd4_q, rd5_q, bank_q[3:0]};
    end

    assign cart_d      = d_oe ? d_dat : 8'hzz;
    assign bus.rom_a   = rom_a_c;
    assign bus.ce_n    = ~(s4_en | s5_en);
    assign bus.oe_n    = ~(s4_en | s5_en) | ~bus.r_w;
    assign bus.we_n    = 1'b1;
    assign bus.rd4     = rd4_q;
    assign bus.rd5     = rd5_q;
    assign unused_bits = ^{bank_q, cart_d};
endmodule

// File: tb/tb_cart_bank_ctl.sv
// Directed bench for cart_bank_ctl: stimulus queues expected bus responses, a monitor compares them.
module tb_cart_bank_ctl;
    localparam int ROM_AW = 19;

    logic phi2    = 1'b0;
    logic reset_n = 1'b0;
    always #10 phi2 = ~phi2;

    cart_bank_ctl_if #(.ROM_AW(ROM_AW)) bus ();
    wire  [7:0] cart_d;
    wire  [7:0] rom_d;
    logic [7:0] tb_d    = 8'h00;
    logic       tb_d_en = 1'b0;

    assign cart_d = tb_d_en ? tb_d : 8'hzz;
    assign rom_d  = bus.rom_a[7:0] ^ 8'h3C;

    cart_bank_ctl #(
        .ROM_AW(ROM_AW), .SDX_BITS(4), .XEGS_BITS(3),
        .SDX_BASE('h00000), .OSS_BASE('h20000), .CAR_BASE('h28000), .XEGS_BASE('h30000)
    ) dut (
        .phi2(phi2), .reset_n(reset_n), .bus(bus), .cart_d(cart_d), .rom_d(rom_d)
    );

    typedef struct {
        string       name;
        logic        on_rst;
        logic [18:0] ra;
        logic        ce_n;
        logic        oe_n;
        logic        rd4;
        logic        rd5;
        logic [7:0]  d;
        logic        d_z;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %h, want %h", nm, fld, act, exp);
        end
    endtask

    task automatic check_rec(input exp_t e);
        chk(e.name, "rom_a", 32'(bus.rom_a), 32'(e.ra));
        chk(e.name, "ce_n",  32'(bus.ce_n),  32'(e.ce_n));
        chk(e.name, "oe_n",  32'(bus.oe_n),  32'(e.oe_n));
        chk(e.name, "rd4",   32'(bus.rd4),   32'(e.rd4));
        chk(e.name, "rd5",   32'(bus.rd5),   32'(e.rd5));
        chk(e.name, "we_n",  32'(bus.we_n),  32'd1);
        if (e.d_z) begin
            n_vec++;
            if (!(cart_d === 8'hzz || cart_d === 8'h00)) begin
                n_bad++;
                $display("FAIL %s cart_d: got %h, want released", e.name, cart_d);
            end
        end else begin
            chk(e.name, "cart_d", 32'(cart_d), 32'(e.d));
        end
    endtask

    always @(posedge phi2) begin
        #2;
        if (q.size() > 0 && !q[0].on_rst) check_rec(q.pop_front());
    end

    always @(negedge reset_n) begin
        #2;
        if (q.size() > 0 && q[0].on_rst) check_rec(q.pop_front());
    end

    task automatic drive(input logic s4, input logic s5, input logic cctl, input logic rw,
                         input logic [12:0] a, input logic [7:0] d, input logic den);
        bus.s4_n   = s4;
        bus.s5_n   = s5;
        bus.cctl_n = cctl;
        bus.r_w    = rw;
        bus.cart_a = a;
        tb_d       = d;
        tb_d_en    = den;
    endtask

    task automatic expect_rd(input string name, input logic s4, input logic s5, input logic cctl,
                             input logic [12:0] a, input logic [18:0] ra, input logic ce,
                             input logic rd4, input logic rd5, input logic [7:0] d, input logic dz);
        exp_t e;
        @(negedge phi2);
        drive(s4, s5, cctl, 1'b1, a, 8'h00, 1'b0);
        e.name = name; e.on_rst = 1'b0; e.ra = ra; e.ce_n = ce; e.oe_n = ce;
        e.rd4 = rd4; e.rd5 = rd5; e.d = d; e.d_z = dz;
        q.push_back(e);
        @(posedge phi2); #4;
    endtask

    task automatic stat(input string name, input logic rd4, input logic rd5, input logic [7:0] d);
        expect_rd(name, 1'b1, 1'b1, 1'b0, 13'h00C0, 19'h0, 1'b1, rd4, rd5, d, 1'b0);
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        @(negedge phi2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, a, d, 1'b1);
        @(posedge phi2); #4;
    endtask

    task automatic do_reset(input logic [1:0] cfg);
        @(negedge phi2);
        reset_n = 1'b0;
        bus.cfg = cfg;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 13'h0, 8'h00, 1'b0);
        repeat (2) @(negedge phi2);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t er;
        bus.cfg = 2'b11;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 13'h0, 8'h00, 1'b0);
        // Held in reset: nothing enabled, no address, bus released.
        expect_rd("rst_state", 1'b0, 1'b0, 1'b1, 13'h0123, 19'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // SDX
        do_reset(2'b10);
        expect_rd("sdx_init_a123", 1'b1, 1'b0, 1'b1, 13'h0123, 19'h1E123, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0);
        stat("sdx_stat_init", 1'b0, 1'b1, 8'h9F);
        wr(13'h00E1, 8'h00);
        expect_rd("sdx_bank14", 1'b1, 1'b0, 1'b1, 13'h0000, 19'h1C000, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        wr(13'h00F0, 8'h00);
        expect_rd("sdx_bank7", 1'b1, 1'b0, 1'b1, 13'h0456, 19'h0E456, 1'b0, 1'b0, 1'b1, 8'h6A, 1'b0);
        wr(13'h00EC, 8'h00);
        expect_rd("sdx_off", 1'b1, 1'b0, 1'b1, 13'h0000, 19'h0E000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        stat("sdx_stat_off", 1'b0, 1'b0, 8'h87);
        wr(13'h00E8, 8'h00);
        expect_rd("sdx_to_plain", 1'b1, 1'b0, 1'b1, 13'h0010, 19'h28010, 1'b0, 1'b0, 1'b1, 8'h2C, 1'b0);
        bus.cfg = 2'b01;
        wr(13'h00E1, 8'h00);
        stat("plain_ignores_wr_cfg", 1'b0, 1'b1, 8'h17);

        // OSS
        do_reset(2'b01);
        stat("oss_stat_init", 1'b0, 1'b1, 8'h50);
        expect_rd("oss_bank0", 1'b1, 1'b0, 1'b1, 13'h0010, 19'h20010, 1'b0, 1'b0, 1'b1, 8'h2C, 1'b0);
        wr(13'h0004, 8'h00);
        expect_rd("oss_bank1", 1'b1, 1'b0, 1'b1, 13'h0010, 19'h21010, 1'b0, 1'b0, 1'b1, 8'h2C, 1'b0);
        wr(13'h0001, 8'h00);
        expect_rd("oss_illegal_ff", 1'b1, 1'b0, 1'b1, 13'h0000, 19'h23000, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        expect_rd("oss_fixed_b000", 1'b1, 1'b0, 1'b1, 13'h1000, 19'h23000, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        stat("oss_stat_b3", 1'b0, 1'b1, 8'h53);
        wr(13'h0003, 8'h00);
        expect_rd("oss_bank2", 1'b1, 1'b0, 1'b1, 13'h0234, 19'h22234, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0);
        wr(13'h0008, 8'h00);
        stat("oss_stat_off", 1'b0, 1'b0, 8'h42);
        expect_rd("oss_off", 1'b1, 1'b0, 1'b1, 13'h1000, 19'h23000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // XEGS
        do_reset(2'b11);
        stat("xegs_stat_init", 1'b1, 1'b1, 8'hF0);
        expect_rd("xegs_b0_8000", 1'b0, 1'b1, 1'b1, 13'h0000, 19'h30000, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
        wr(13'h0000, 8'h05);
        expect_rd("xegs_b5_8000", 1'b0, 1'b1, 1'b1, 13'h0000, 19'h3A000, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
        expect_rd("xegs_fixed_a000", 1'b1, 1'b0, 1'b1, 13'h0100, 19'h3E100, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0);
        stat("xegs_stat_b5", 1'b1, 1'b1, 8'hF5);
        expect_rd("xegs_both_sel", 1'b0, 1'b0, 1'b1, 13'h0001, 19'h3A001, 1'b0, 1'b1, 1'b1, 8'h3D, 1'b0);
        wr(13'h0000, 8'h0E);
        stat("xegs_trunc_b6", 1'b1, 1'b1, 8'hF6);
        wr(13'h0000, 8'h80);
        stat("xegs_stat_off", 1'b0, 1'b0, 8'hC0);
        expect_rd("xegs_off", 1'b0, 1'b1, 1'b1, 13'h0000, 19'h30000, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        wr(13'h0000, 8'h05);

        // Asynchronous reset in the middle of phi2 high
        @(negedge phi2);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 13'h0002, 8'h00, 1'b0);
        er.name = "rst_midphase"; er.on_rst = 1'b1; er.ra = 19'h0; er.ce_n = 1'b1; er.oe_n = 1'b1;
        er.rd4 = 1'b0; er.rd5 = 1'b0; er.d = 8'h00; er.d_z = 1'b1;
        q.push_back(er);
        @(posedge phi2); #5;
        reset_n = 1'b0;
        bus.cfg = 2'b00;
        #3;
        do_reset(2'b00);
        stat("plain_after_reset", 1'b0, 1'b1, 8'h10);
        expect_rd("plain_a010", 1'b1, 1'b0, 1'b1, 13'h0010, 19'h28010, 1'b0, 1'b0, 1'b1, 8'h2C, 1'b0);

        repeat (3) @(negedge phi2);
        chk("queue_drained", "pending", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
